// File: rtl/ram_rw_checker.sv
// ram_rw_checker: write/read-back tester for a simple dual-port RAM.
// A start pulse writes (address + seed) to every location, reads every
// location back, lines each returned word up with its expected value across
// the RAM's read latency, counts mismatches and reports pass/fail.
module ram_rw_checker #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 2,
    parameter int ERR_WIDTH  = 8
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_WIDTH-1:0]  err_cnt,
    output logic [ADDR_WIDTH-1:0] first_err_addr
);

    localparam int EXT_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int DRAIN_W = $clog2(RD_LATENCY + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(RD_LATENCY - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t                 state_reg;
    logic [DATA_WIDTH-1:0]  seed_reg;
    logic [DRAIN_W-1:0]     drain_cnt_reg;
    logic                   first_seen_reg;

    // Read-tracking pipe: stage RD_LATENCY-1 describes the word on rd_data now
    logic [RD_LATENCY-1:0]  pipe_valid_reg;
    logic [ADDR_WIDTH-1:0]  pipe_addr_reg [RD_LATENCY];

    logic                   cmp_valid;
    logic [ADDR_WIDTH-1:0]  cmp_addr;
    logic [DATA_WIDTH-1:0]  cmp_expected;
    logic                   mismatch;
    logic [ERR_WIDTH-1:0]   err_next;

    // Address zero-extended or truncated to the data width
    function automatic logic [DATA_WIDTH-1:0] addr_to_data(input logic [ADDR_WIDTH-1:0] a);
        logic [EXT_W-1:0] ext;
        ext = EXT_W'(a);
        return ext[DATA_WIDTH-1:0];
    endfunction

    // Compare the returned word against the pattern and form the next error count
    always_comb begin
        cmp_valid    = pipe_valid_reg[RD_LATENCY-1];
        cmp_addr     = pipe_addr_reg[RD_LATENCY-1];
        cmp_expected = addr_to_data(cmp_addr) + seed_reg;
        mismatch     = cmp_valid && (rd_data != cmp_expected);
        err_next     = err_cnt;
        if (mismatch && (err_cnt != '1)) begin
            err_next = err_cnt + 1'b1;
        end
    end

    // Shift read addresses along so they arrive together with their data
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_valid_reg <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_addr_reg[i] <= '0;
            end
        end else begin
            for (int i = RD_LATENCY - 1; i > 0; i--) begin
                pipe_valid_reg[i] <= pipe_valid_reg[i-1];
                pipe_addr_reg[i]  <= pipe_addr_reg[i-1];
            end
            pipe_valid_reg[0] <= (state_reg == ST_READ);
            pipe_addr_reg[0]  <= rd_addr;
        end
    end

    // Sequencer with registered RAM-side and status outputs
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            seed_reg       <= '0;
            drain_cnt_reg  <= '0;
            first_seen_reg <= 1'b0;
            wr_en          <= 1'b0;
            wr_addr        <= '0;
            wr_data        <= '0;
            rd_addr        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
        end else begin
            err_cnt <= err_next;
            if (mismatch && !first_seen_reg) begin
                first_err_addr <= cmp_addr;
                first_seen_reg <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    wr_en   <= 1'b0;
                    wr_addr <= '0;
                    wr_data <= '0;
                    rd_addr <= '0;
                    done    <= 1'b0;
                    if (start) begin
                        seed_reg       <= seed;
                        err_cnt        <= '0;
                        first_err_addr <= '0;
                        first_seen_reg <= 1'b0;
                        pass           <= 1'b0;
                        wr_en          <= 1'b1;
                        wr_data        <= seed;
                        busy           <= 1'b1;
                        state_reg      <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (wr_addr == LAST_ADDR) begin
                        wr_en     <= 1'b0;
                        wr_addr   <= '0;
                        wr_data   <= '0;
                        rd_addr   <= '0;
                        state_reg <= ST_READ;
                    end else begin
                        wr_addr <= wr_addr + 1'b1;
                        wr_data <= addr_to_data(wr_addr + 1'b1) + seed_reg;
                    end
                end
                ST_READ: begin
                    if (rd_addr == LAST_ADDR) begin
                        drain_cnt_reg <= '0;
                        state_reg     <= ST_DRAIN;
                    end else begin
                        rd_addr <= rd_addr + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // The last compare lands on this same edge, so use err_next
                    if (drain_cnt_reg == DRAIN_LAST) begin
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        pass      <= (err_next == '0);
                        state_reg <= ST_DONE;
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg + 1'b1;
                    end
                end
                ST_DONE: begin
                    done      <= 1'b0;
                    rd_addr   <= '0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_rw_checker.sv
// tb_ram_rw_checker: directed bench for ram_rw_checker with a small RAM model
// whose read latency can be switched between 2 and 3 cycles.
module tb_ram_rw_checker;

    logic       sys_clk;
    logic       rst_n;
    logic       start;
    logic [7:0] seed;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic [5:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_cnt;
    logic [5:0] first_err_addr;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int lat   = 2;
    logic corrupt_req = 1'b0;

    ram_rw_checker dut (
        .sys_clk        (sys_clk),
        .rst_n          (rst_n),
        .start          (start),
        .seed           (seed),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // RAM model: storage plus a read path whose first stage loads only while
    // the checker is reading, followed by output registers reset to 0.
    logic [7:0] mem [64];
    logic [7:0] s1, s2, s3;
    logic       rd_en;

    assign rd_en   = busy & ~wr_en;
    assign rd_data = (lat == 3) ? s3 : s2;

    always @(posedge sys_clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (corrupt_req) begin
            mem[6'h05] <= ~mem[6'h05];
            mem[6'h2A] <= mem[6'h2A] ^ 8'h55;
        end
    end

    always @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 8'h00;
            s2 <= 8'h00;
            s3 <= 8'h00;
        end else begin
            s1 <= rd_en ? mem[rd_addr] : 8'h00;
            s2 <= s1;
            s3 <= s2;
        end
    end

    typedef struct {
        logic [7:0] seed;
        int         lat;
        bit         corrupt;
        logic [7:0] exp_err;
        logic [5:0] exp_first;
        bit         exp_pass;
        logic [5:0] chk_addr_a;
        logic [7:0] chk_val_a;
        logic [5:0] chk_addr_b;
        logic [7:0] chk_val_b;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge
    task automatic step();
        @(posedge sys_clk);
        #1;
        cyc++;
    endtask

    // One test pass from start acceptance (cycle 0) until done is seen
    task automatic run_pass(input logic [7:0] s, input bit corrupt, input int pulse_cyc,
                            output int done_cyc);
        seed  = s;
        start = 1'b1;
        cyc   = 0;
        step();
        start = 1'b0;
        check("wr_first_en",   {31'd0, wr_en}, 32'd1);
        check("wr_first_addr", {26'd0, wr_addr}, 32'd0);
        check("wr_first_data", {24'd0, wr_data}, {24'd0, s});
        check("busy_first",    {31'd0, busy}, 32'd1);
        while (done !== 1'b1 && cyc < 400) begin
            if (cyc == 64) begin
                check("wr_last_addr", {26'd0, wr_addr}, 32'h3F);
                check("wr_last_data", {24'd0, wr_data}, {24'd0, 8'(8'h3F + s)});
            end
            if (cyc == 65) begin
                check("rd_first_wr_en", {31'd0, wr_en}, 32'd0);
                check("rd_first_addr",  {26'd0, rd_addr}, 32'd0);
            end
            corrupt_req = corrupt && (cyc == 65);
            start       = (cyc == pulse_cyc);
            step();
        end
        corrupt_req = 1'b0;
        start       = 1'b0;
        done_cyc    = (done === 1'b1) ? cyc : -1;
    endtask

    initial begin
        int dc;
        int bad_words;

        vecs[0] = '{8'h00, 2, 1'b0, 8'd0,  6'h00, 1'b1, 6'h00, 8'h00, 6'h3F, 8'h3F};
        vecs[1] = '{8'hF0, 2, 1'b0, 8'd0,  6'h00, 1'b1, 6'h0F, 8'hFF, 6'h10, 8'h00};
        vecs[2] = '{8'h5A, 2, 1'b1, 8'd2,  6'h05, 1'b0, 6'h06, 8'h60, 6'h2B, 8'h85};
        vecs[3] = '{8'h01, 3, 1'b0, 8'd64, 6'h00, 1'b0, 6'h00, 8'h01, 6'h3F, 8'h40};

        // Reset held with start asserted: everything stays at zero
        rst_n = 1'b0;
        start = 1'b1;
        seed  = 8'hAB;
        repeat (3) step();
        check("rst_wr_en",   {31'd0, wr_en}, 32'd0);
        check("rst_wr_addr", {26'd0, wr_addr}, 32'd0);
        check("rst_wr_data", {24'd0, wr_data}, 32'd0);
        check("rst_rd_addr", {26'd0, rd_addr}, 32'd0);
        check("rst_busy",    {31'd0, busy}, 32'd0);
        check("rst_done",    {31'd0, done}, 32'd0);
        check("rst_pass",    {31'd0, pass}, 32'd0);
        check("rst_err",     {24'd0, err_cnt}, 32'd0);
        check("rst_first",   {26'd0, first_err_addr}, 32'd0);
        $display("reset held: outputs checked");

        rst_n = 1'b1;
        start = 1'b0;
        repeat (3) step();
        check("idle_busy",  {31'd0, busy}, 32'd0);
        check("idle_wr_en", {31'd0, wr_en}, 32'd0);
        check("idle_done",  {31'd0, done}, 32'd0);
        $display("reset released with start low: idle checked");

        // Table of full passes
        for (int i = 0; i < 4; i++) begin
            lat = vecs[i].lat;
            run_pass(vecs[i].seed, vecs[i].corrupt, -1, dc);
            check("done_cycle", dc, 131);
            check("done_busy",  {31'd0, busy}, 32'd0);
            check("pass",       {31'd0, pass}, {31'd0, vecs[i].exp_pass});
            check("err_cnt",    {24'd0, err_cnt}, {24'd0, vecs[i].exp_err});
            check("first_err",  {26'd0, first_err_addr}, {26'd0, vecs[i].exp_first});
            check("mem_a",      {24'd0, mem[vecs[i].chk_addr_a]}, {24'd0, vecs[i].chk_val_a});
            check("mem_b",      {24'd0, mem[vecs[i].chk_addr_b]}, {24'd0, vecs[i].chk_val_b});
            if (!vecs[i].corrupt) begin
                bad_words = 0;
                for (int a = 0; a < 64; a++) begin
                    if (mem[a] !== 8'(a + int'(vecs[i].seed))) bad_words++;
                end
                check("mem_pattern", bad_words, 0);
            end
            step();
            check("done_pulse_len", {31'd0, done}, 32'd0);
            check("pass_hold",      {31'd0, pass}, {31'd0, vecs[i].exp_pass});
            $display("vector %0d: seed=%02h lat=%0d done_cyc=%0d err=%0d first=%02h pass=%0b",
                     i, vecs[i].seed, vecs[i].lat, dc, err_cnt, first_err_addr, pass);
        end

        // start pulsed during READ is ignored
        lat = 2;
        run_pass(8'h33, 1'b0, 70, dc);
        check("ignore_done_cycle", dc, 131);
        check("ignore_pass",       {31'd0, pass}, 32'd1);
        repeat (5) step();
        check("ignore_no_restart", {31'd0, busy}, 32'd0);
        check("ignore_no_done",    {31'd0, done}, 32'd0);
        $display("start during READ: done_cyc=%0d busy=%0b", dc, busy);

        // Asynchronous reset in cycle 80 of a failing (3-cycle) pass
        lat   = 3;
        seed  = 8'h10;
        start = 1'b1;
        cyc   = 0;
        step();
        start = 1'b0;
        while (cyc < 80) step();
        check("pre_reset_err", {24'd0, err_cnt}, 32'd13);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_wr_en",   {31'd0, wr_en}, 32'd0);
        check("async_busy",    {31'd0, busy}, 32'd0);
        check("async_err",     {24'd0, err_cnt}, 32'd0);
        check("async_rd_addr", {26'd0, rd_addr}, 32'd0);
        check("async_first",   {26'd0, first_err_addr}, 32'd0);
        $display("reset in cycle 80: wr_en=%0b busy=%0b err=%0d", wr_en, busy, err_cnt);
        @(posedge sys_clk);
        #1;
        rst_n = 1'b1;
        lat   = 2;
        step();

        // Normal pass after the interrupted one
        run_pass(8'h77, 1'b0, -1, dc);
        check("post_reset_done_cycle", dc, 131);
        check("post_reset_pass",       {31'd0, pass}, 32'd1);
        check("post_reset_err",        {24'd0, err_cnt}, 32'd0);
        $display("pass after reset: done_cyc=%0d pass=%0b err=%0d", dc, pass, err_cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_rw_checker.md
# ram_rw_checker

Single-clock write/read-back controller that drives the write and read ports of the 64 x 8 simple dual-port RAM core and checks what comes back.
- On a start pulse it writes a seeded pattern to every address, reads every address back, and aligns each returned word with its expected value across the RAM's fixed read latency.
- It counts mismatches and reports pass/fail.
- It sits between the board-level start logic and the RAM: upstream of the RAM's wr_/rd_addr ports, downstream of its rd_data.

## Interface
Parameters:
- ADDR_WIDTH, 6, RAM address width; depth = 2^ADDR_WIDTH.
- DATA_WIDTH, 8, RAM data width.
- RD_LATENCY, 2, cycles from rd_addr presented to matching rd_data on input (RAM output register enabled).
- ERR_WIDTH, 8, width of error counter.

Ports:
- sys_clk  in  1  sole clock; both RAM port clocks are tied to it.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a test pass; sampled only in IDLE.
- seed  in  DATA_WIDTH  pattern offset; captured when start is accepted.
- wr_en  out  1  RAM write enable.
- wr_addr  out  ADDR_WIDTH  RAM write address.
- wr_data  out  DATA_WIDTH  RAM write data.
- rd_addr  out  ADDR_WIDTH  RAM read address.
- rd_data  in  DATA_WIDTH  RAM read data, RD_LATENCY cycles behind rd_addr.
- busy  out  1  high from the first WRITE cycle through the last DRAIN cycle.
- done  out  1  one-cycle pulse when results are final.
- pass  out  1  1 if the last completed test had err_cnt == 0.
- err_cnt  out  ERR_WIDTH  mismatches in the last or current test; saturates at all-ones.
- first_err_addr  out  ADDR_WIDTH  address of the first mismatch in the current or last test.

## Operation
- States: IDLE -> WRITE -> READ -> DRAIN -> DONE -> IDLE.
- IDLE:
  - Outputs wr_en=0, wr_addr=0, wr_data=0, rd_addr=0.
  - If start=1: latch seed, clear err_cnt, first_err_addr and pass, then enter WRITE.
- WRITE: wr_en=1 with wr_addr counting 0..depth-1, one per cycle.
  - wr_data = (wr_addr zero-extended or truncated to DATA_WIDTH) + seed_q, modulo 2^DATA_WIDTH.
  - After address depth-1, enter READ; wr_en=0 from then on.
- READ: rd_addr counts 0..depth-1, one per cycle. Each cycle also pushes {valid=1, addr} into a RD_LATENCY-deep shift pipe.
  - After address depth-1, enter DRAIN.
- DRAIN: lasts RD_LATENCY cycles, pushing valid=0 into the pipe. rd_addr holds depth-1.
- Compare: whenever the pipe output is valid, compare rd_data with (pipe addr + seed_q) mod 2^DATA_WIDTH.
  - On mismatch, err_cnt increments, saturating.
  - The first mismatch of a test loads first_err_addr.
- DONE: one cycle.
  - done=1 and pass=(err_cnt==0). pass holds until the next accepted start.
  - Return to IDLE.
- start is ignored outside IDLE. A start held high in DONE is not accepted until IDLE.
- rst_n low at any time, including mid-WRITE or mid-READ:
  - State goes to IDLE; the pipe and all registers clear.
  - Every output is 0 immediately (asynchronous).
  - A partially written RAM is not cleaned up.
- All outputs are registered.

## Timing
- Reset values: wr_en, wr_addr, wr_data, rd_addr, busy, done, pass, err_cnt, first_err_addr all 0.
- Let cycle 0 be the cycle in which start=1 is sampled in IDLE. With defaults (depth 64, latency 2):
  - Cycles 1-64: WRITE, addresses 0-63.
  - Cycles 65-128: READ, rd_addr 0-63.
  - Cycles 129-130: DRAIN.
  - Read data for rd_addr presented in cycle k is compared at the end of cycle k+2; address 63 is compared at the end of cycle 130.
  - Cycle 131: done=1, busy=0, with pass and err_cnt final in that cycle.
  - Cycle 132: IDLE; a new start is accepted from cycle 132.
- General form: done in cycle 2*depth + RD_LATENCY + 1.
- No read-during-write hazard: every read of address a follows its write by at least depth cycles.

## Test plan
- Reset: hold rst_n=0, drive start=1 -> all outputs 0, no wr_en. Release rst_n with start=0 -> stays IDLE.
- Seed 0x00 with an ideal 2-cycle RAM model:
  - Writes 0x00..0x3F to addresses 0..63.
  - done in cycle 131; pass=1; err_cnt=0.
- Seed 0xF0:
  - Address 0x0F gets 0xFF; address 0x10 gets 0x00 (wrap).
  - pass=1.
- Bench corrupts RAM addresses 0x05 and 0x2A after WRITE -> err_cnt=2, first_err_addr=0x05, pass=0.
- start pulsed during READ -> ignored, done in cycle 131 only. Then rst_n low in cycle 80:
  - wr_en=0, busy=0, err_cnt=0 immediately.
  - The next start completes normally.
- Bench RAM with 3-cycle latency (output register reset 0), seed 0x01 -> every comparison is misaligned: err_cnt=64, first_err_addr=0x00, pass=0.
